// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor-control ADC front end.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        UPDATE = 2'd2
    } adc_state_t;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_DATA_BITS  = 12;
    localparam int unsigned ADC_ADDR_MSB   = 13;
    localparam int unsigned ADC_HALF_BITS  = 5;   // 32 SCLK half-periods per frame

    localparam logic CH_PHASE  = 1'b0;
    localparam logic CH_ASSIST = 1'b1;

    // Control word shifted out on DIN: {2'b00, addr[2:0], 11'b0}
    function automatic logic [ADC_FRAME_BITS-1:0] adc_frame_word(input logic [2:0] addr);
        logic [ADC_FRAME_BITS-1:0] w;
        w = '0;
        w[ADC_ADDR_MSB -: 3] = addr;
        return w;
    endfunction

endpackage

// File: rtl/adc_boxcar4.sv
// 4-deep boxcar average of 12-bit samples, advanced on load.
// Only present when PHASE_ADC_AVG_EN is defined.
`ifdef PHASE_ADC_AVG_EN
module adc_boxcar4
    import motor_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [11:0] din,
    output logic [11:0] dout
);

    localparam int unsigned SUM_W = ADC_DATA_BITS + 2;

    logic [2:0][11:0]  hist_q;
    logic [SUM_W-1:0]  sum_c;
    logic [11:0]       dout_q;

    // Sum of the incoming sample and the three previous ones
    always_comb begin
        sum_c = SUM_W'(din) + SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]);
    end

    // History shift and registered average (truncating divide by 4)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= '0;
            dout_q <= '0;
        end else if (load) begin
            hist_q[0] <= din;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            dout_q    <= sum_c[SUM_W-1:2];
        end
    end

    assign dout = dout_q;

endmodule
`endif

// File: rtl/phase_adc_sampler.sv
// SPI front end for an ADC128S022-type ADC: alternates between the phase-wire
// and assistance channels and publishes the latest 12-bit value of each.
// Optional averaging: define PHASE_ADC_AVG_EN to pass each channel through a
// 4-deep boxcar (adc_boxcar4).
module phase_adc_sampler
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned SCLK_DIV    = 2,
    parameter int unsigned IDLE_CYCLES = 4,
    parameter logic [2:0]  PHASE_CH    = 3'd0,
    parameter logic [2:0]  ASSIST_CH   = 3'd1
)
(
    input  logic        c1m,
    input  logic        reset_n,
    input  logic        adc_miso,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_mosi,
    output logic [11:0] PhaseWireVoltage,
    output logic [11:0] AssistanceRequirement,
    output logic        sample_valid,
    output logic        sample_ch
);

    localparam int unsigned CNT_MAX = (IDLE_CYCLES > SCLK_DIV) ? IDLE_CYCLES : SCLK_DIV;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]         IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]         DIV_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [ADC_HALF_BITS-1:0] HALF_LAST = '1;

    adc_state_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADC_HALF_BITS-1:0]  half_q, half_d;
    logic                      cs_n_q, cs_n_d;
    logic                      sclk_q, sclk_d;
    logic                      mosi_q, mosi_d;

    logic [ADC_DATA_BITS-1:0]  rx_shift_q;
    logic                      tx_ch_q;
    logic                      rx_ch_q;
    logic                      first_q;
    logic                      valid_q;
    logic                      ch_q;
    logic [ADC_DATA_BITS-1:0]  phase_q;
    logic [ADC_DATA_BITS-1:0]  assist_q;

    logic [ADC_FRAME_BITS-1:0] tx_word_c;
    logic                      sclk_rise_c;
    logic                      update_c;
    logic                      load_phase_c;
    logic                      load_assist_c;

    assign tx_word_c     = adc_frame_word((tx_ch_q == CH_ASSIST) ? ASSIST_CH : PHASE_CH);
    assign sclk_rise_c   = (state_q == FRAME) && half_q[0] && (cnt_q == '0);
    assign update_c      = (state_q == UPDATE) && !first_q;
    assign load_phase_c  = update_c && (rx_ch_q == CH_PHASE);
    assign load_assist_c = update_c && (rx_ch_q == CH_ASSIST);

    // Next state, divider/half-period counters and pin values aligned to the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        mosi_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = FRAME;
                    cnt_d   = '0;
                    half_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FRAME: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = UPDATE;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                half_d  = '0;
            end
        endcase

        if (state_d == FRAME) begin
            cs_n_d = 1'b0;
            sclk_d = half_d[0];
            mosi_d = tx_word_c[~half_d[4:1]];
        end
    end

    // FSM, counters and registered SPI pins
    always_ff @(posedge c1m) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    // MISO capture, channel pipeline and valid strobe
    always_ff @(posedge c1m) begin
        if (!reset_n) begin
            rx_shift_q <= '0;
            tx_ch_q    <= CH_PHASE;
            rx_ch_q    <= CH_PHASE;
            first_q    <= 1'b1;
            valid_q    <= 1'b0;
            ch_q       <= CH_PHASE;
        end else begin
            valid_q <= update_c;
            if (update_c) begin
                ch_q <= rx_ch_q;
            end
            if (sclk_rise_c) begin
                rx_shift_q <= {rx_shift_q[ADC_DATA_BITS-2:0], adc_miso};
            end
            if (state_q == UPDATE) begin
                first_q <= 1'b0;
                rx_ch_q <= tx_ch_q;
                tx_ch_q <= ~tx_ch_q;
            end
        end
    end

`ifdef PHASE_ADC_AVG_EN
    adc_boxcar4 u_phase_avg (
        .clk     (c1m),
        .reset_n (reset_n),
        .load    (load_phase_c),
        .din     (rx_shift_q),
        .dout    (phase_q)
    );

    adc_boxcar4 u_assist_avg (
        .clk     (c1m),
        .reset_n (reset_n),
        .load    (load_assist_c),
        .din     (rx_shift_q),
        .dout    (assist_q)
    );
`else
    // Raw frame data into the channel that was addressed one frame earlier
    always_ff @(posedge c1m) begin
        if (!reset_n) begin
            phase_q  <= '0;
            assist_q <= '0;
        end else begin
            if (load_phase_c) begin
                phase_q <= rx_shift_q;
            end
            if (load_assist_c) begin
                assist_q <= rx_shift_q;
            end
        end
    end
`endif

    assign adc_sclk              = sclk_q;
    assign adc_cs_n              = cs_n_q;
    assign adc_mosi              = mosi_q;
    assign PhaseWireVoltage      = phase_q;
    assign AssistanceRequirement = assist_q;
    assign sample_valid          = valid_q;
    assign sample_ch             = ch_q;

endmodule

// File: tb/tb_phase_adc_sampler.sv
// Directed bench for phase_adc_sampler: default instance (a) and a fast
// instance (b, SCLK_DIV=1, IDLE_CYCLES=1), each driven by a small ADC model.
module tb_phase_adc_sampler;

    logic c1m = 1'b0;
    always #5 c1m = ~c1m;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge c1m) cyc++;

    logic a_rst_n = 1'b0;
    logic b_rst_n = 1'b0;
    logic a_sclk, a_cs_n, a_mosi, a_valid, a_ch;
    logic b_sclk, b_cs_n, b_mosi, b_valid, b_ch;
    logic [11:0] a_phase, a_assist, b_phase, b_assist;
    logic [1:0] miso_v = 2'b00;

    phase_adc_sampler u_a (
        .c1m(c1m), .reset_n(a_rst_n), .adc_miso(miso_v[0]),
        .adc_sclk(a_sclk), .adc_cs_n(a_cs_n), .adc_mosi(a_mosi),
        .PhaseWireVoltage(a_phase), .AssistanceRequirement(a_assist),
        .sample_valid(a_valid), .sample_ch(a_ch)
    );

    phase_adc_sampler #(.SCLK_DIV(1), .IDLE_CYCLES(1)) u_b (
        .c1m(c1m), .reset_n(b_rst_n), .adc_miso(miso_v[1]),
        .adc_sclk(b_sclk), .adc_cs_n(b_cs_n), .adc_mosi(b_mosi),
        .PhaseWireVoltage(b_phase), .AssistanceRequirement(b_assist),
        .sample_valid(b_valid), .sample_ch(b_ch)
    );

    // ADC model state, one slot per instance
    logic [1:0]  cs_v, sclk_v, mosi_v;
    assign cs_v   = {b_cs_n, a_cs_n};
    assign sclk_v = {b_sclk, a_sclk};
    assign mosi_v = {b_mosi, a_mosi};

    logic [11:0] dat [2][2];
    logic        cs_prev   [2] = '{1'b1, 1'b1};
    logic        sclk_prev [2] = '{1'b1, 1'b1};
    logic [15:0] resp [2];
    logic [15:0] rx   [2];
    logic [2:0]  cur_addr [2] = '{3'd0, 3'd0};
    int          rises [2];
    int          nframes [2] = '{0, 0};
    int          rise_cyc [2];
    logic [15:0] wlog [2][64];
    int          rlog [2][64];

    // ADC behaviour: DOUT shifts on SCLK falls, DIN captured on rises,
    // address takes effect on the following frame
    always @(posedge c1m) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (!cs_v[g] && cs_prev[g]) begin
                case (cur_addr[g])
                    3'd0:    resp[g] = {4'h0, dat[g][0]};
                    3'd1:    resp[g] = {4'h0, dat[g][1]};
                    default: resp[g] = 16'h0000;
                endcase
                rises[g] = 0;
                rx[g]    = 16'h0000;
            end
            if (!cs_v[g] && sclk_prev[g] && !sclk_v[g]) begin
                miso_v[g] = resp[g][15];
                resp[g]   = {resp[g][14:0], 1'b0};
            end
            if (!cs_v[g] && !sclk_prev[g] && sclk_v[g]) begin
                rx[g] = {rx[g][14:0], mosi_v[g]};
                rises[g]++;
            end
            if (cs_v[g] && !cs_prev[g]) begin
                if (nframes[g] < 64) begin
                    wlog[g][nframes[g]] = rx[g];
                    rlog[g][nframes[g]] = rises[g];
                end
                cur_addr[g] = rx[g][13:11];
                rise_cyc[g] = cyc;
                nframes[g]++;
            end
            cs_prev[g]   = cs_v[g];
            sclk_prev[g] = sclk_v[g];
        end
    end

    // Count back-to-back valid pulses on either instance
    logic a_vp = 1'b0;
    logic b_vp = 1'b0;
    int   consec = 0;
    always @(negedge c1m) begin
        if (a_valid && a_vp) consec++;
        if (b_valid && b_vp) consec++;
        a_vp = a_valid;
        b_vp = b_valid;
    end

    task automatic wait_valid(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge c1m);
            if ((which == 0) ? a_valid : b_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge c1m);
        @(negedge c1m);
        checks++; if (a_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b expected 1", a_cs_n); end
        checks++; if (a_sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk: got %b expected 1", a_sclk); end
        checks++; if (a_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", a_mosi); end
        checks++; if (a_phase !== 12'h000) begin failures++; $display("FAIL reset_phase: got %h expected 000", a_phase); end
        checks++; if (a_assist !== 12'h000) begin failures++; $display("FAIL reset_assist: got %h expected 000", a_assist); end
        checks++; if (a_valid !== 1'b0 || a_ch !== 1'b0) begin failures++; $display("FAIL reset_valid_ch: got %b%b expected 00", a_valid, a_ch); end
        checks++; if (b_cs_n !== 1'b1 || b_sclk !== 1'b1) begin failures++; $display("FAIL reset_b_pins: got %b%b expected 11", b_cs_n, b_sclk); end
    endtask

    task automatic test_basic();
        bit ok;
        int t1;
        dat[0][0] = 12'hA5C;
        dat[0][1] = 12'h3F1;
        a_rst_n = 1'b1;
        wait_valid(0, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_first_valid: got timeout expected pulse"); end
        checks++; if (nframes[0] !== 2) begin failures++; $display("FAIL basic_discard: got %0d frames expected 2", nframes[0]); end
        checks++; if (a_phase !== 12'hA5C) begin failures++; $display("FAIL basic_phase: got %h expected a5c", a_phase); end
        checks++; if (a_ch !== 1'b0) begin failures++; $display("FAIL basic_ch0: got %b expected 0", a_ch); end
        checks++; if (a_assist !== 12'h000) begin failures++; $display("FAIL basic_assist_hold0: got %h expected 000", a_assist); end
        checks++; if (cyc - rise_cyc[0] !== 1) begin failures++; $display("FAIL basic_latency: got %0d expected 1", cyc - rise_cyc[0]); end
        t1 = cyc;
        wait_valid(0, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_second_valid: got timeout expected pulse"); end
        checks++; if (cyc - t1 !== 69) begin failures++; $display("FAIL basic_period: got %0d expected 69", cyc - t1); end
        checks++; if (a_assist !== 12'h3F1) begin failures++; $display("FAIL basic_assist: got %h expected 3f1", a_assist); end
        checks++; if (a_ch !== 1'b1) begin failures++; $display("FAIL basic_ch1: got %b expected 1", a_ch); end
        checks++; if (a_phase !== 12'hA5C) begin failures++; $display("FAIL basic_phase_hold: got %h expected a5c", a_phase); end
    endtask

    task automatic test_edges();
        bit ok;
        dat[0][0] = 12'h000;
        dat[0][1] = 12'hFFF;
        wait_valid(0, 100, ok);
        checks++; if (!ok || a_ch !== 1'b0 || a_phase !== 12'h000) begin failures++; $display("FAIL edge_phase_zero: got ch=%b %h expected ch=0 000", a_ch, a_phase); end
        checks++; if (a_assist !== 12'h3F1) begin failures++; $display("FAIL edge_assist_hold: got %h expected 3f1", a_assist); end
        wait_valid(0, 100, ok);
        checks++; if (!ok || a_ch !== 1'b1 || a_assist !== 12'hFFF) begin failures++; $display("FAIL edge_assist_full: got ch=%b %h expected ch=1 fff", a_ch, a_assist); end
        checks++; if (a_phase !== 12'h000) begin failures++; $display("FAIL edge_phase_hold0: got %h expected 000", a_phase); end
        dat[0][0] = 12'hFFF;
        dat[0][1] = 12'h000;
        wait_valid(0, 100, ok);
        checks++; if (!ok || a_ch !== 1'b0 || a_phase !== 12'hFFF) begin failures++; $display("FAIL edge_phase_full: got ch=%b %h expected ch=0 fff", a_ch, a_phase); end
        checks++; if (a_assist !== 12'hFFF) begin failures++; $display("FAIL edge_assist_holdf: got %h expected fff", a_assist); end
        wait_valid(0, 100, ok);
        checks++; if (!ok || a_ch !== 1'b1 || a_assist !== 12'h000) begin failures++; $display("FAIL edge_assist_zero: got ch=%b %h expected ch=1 000", a_ch, a_assist); end
        checks++; if (a_phase !== 12'hFFF) begin failures++; $display("FAIL edge_phase_holdf: got %h expected fff", a_phase); end
    endtask

    task automatic test_mosi();
        logic [15:0] exp_w;
        for (int i = 0; i < 6; i++) begin
            exp_w = (i % 2 == 1) ? 16'h0800 : 16'h0000;
            checks++; if (wlog[0][i] !== exp_w) begin failures++; $display("FAIL mosi_word%0d: got %h expected %h", i, wlog[0][i], exp_w); end
            checks++; if (rlog[0][i] !== 16) begin failures++; $display("FAIL mosi_rises%0d: got %0d expected 16", i, rlog[0][i]); end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int f0;
        for (int i = 0; i < 100 && a_cs_n; i++) @(negedge c1m);
        repeat (10) @(negedge c1m);
        checks++; if (a_cs_n !== 1'b0) begin failures++; $display("FAIL midrst_in_frame: got cs_n=%b expected 0", a_cs_n); end
        a_rst_n = 1'b0;
        @(negedge c1m);
        checks++; if (a_cs_n !== 1'b1 || a_sclk !== 1'b1) begin failures++; $display("FAIL midrst_pins: got %b%b expected 11", a_cs_n, a_sclk); end
        checks++; if (a_phase !== 12'h000 || a_assist !== 12'h000) begin failures++; $display("FAIL midrst_outputs: got %h %h expected 000 000", a_phase, a_assist); end
        checks++; if (a_valid !== 1'b0 || a_ch !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b%b expected 00", a_valid, a_ch); end
        repeat (2) @(negedge c1m);
        dat[0][0] = 12'hA5C;
        dat[0][1] = 12'h3F1;
        f0 = nframes[0];
        a_rst_n = 1'b1;
        wait_valid(0, 300, ok);
        checks++; if (!ok || nframes[0] - f0 !== 2) begin failures++; $display("FAIL midrst_discard: got %0d frames expected 2", nframes[0] - f0); end
        checks++; if (a_ch !== 1'b0 || a_phase !== 12'hA5C || a_assist !== 12'h000) begin failures++; $display("FAIL midrst_restart: got ch=%b %h %h expected ch=0 a5c 000", a_ch, a_phase, a_assist); end
    endtask

    task automatic test_fast();
        bit ok;
        int t1;
        dat[1][0] = 12'h123;
        dat[1][1] = 12'hABC;
        b_rst_n = 1'b1;
        wait_valid(1, 200, ok);
        checks++; if (!ok || nframes[1] !== 2) begin failures++; $display("FAIL fast_discard: got %0d frames expected 2", nframes[1]); end
        checks++; if (b_ch !== 1'b0 || b_phase !== 12'h123) begin failures++; $display("FAIL fast_phase: got ch=%b %h expected ch=0 123", b_ch, b_phase); end
        t1 = cyc;
        wait_valid(1, 100, ok);
        checks++; if (!ok || cyc - t1 !== 34) begin failures++; $display("FAIL fast_period: got %0d expected 34", cyc - t1); end
        checks++; if (b_ch !== 1'b1 || b_assist !== 12'hABC || b_phase !== 12'h123) begin failures++; $display("FAIL fast_assist: got ch=%b %h %h expected ch=1 abc 123", b_ch, b_assist, b_phase); end
        checks++; if (rlog[1][0] !== 16 || wlog[1][1] !== 16'h0800) begin failures++; $display("FAIL fast_frame: got %0d %h expected 16 0800", rlog[1][0], wlog[1][1]); end
        checks++; if (consec !== 0) begin failures++; $display("FAIL no_consec_valid: got %0d expected 0", consec); end
    endtask

`ifdef PHASE_ADC_AVG_EN
    task automatic test_avg();
        bit ok;
        logic [11:0] exp_ph [5];
        exp_ph = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h400};
        dat[0][0] = 12'h400;
        dat[0][1] = 12'h000;
        a_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid(0, 300, ok);
            checks++; if (!ok || a_ch !== 1'b0 || a_phase !== exp_ph[k]) begin failures++; $display("FAIL avg_phase%0d: got ch=%b %h expected ch=0 %h", k, a_ch, a_phase, exp_ph[k]); end
            wait_valid(0, 100, ok);
            checks++; if (!ok || a_ch !== 1'b1 || a_assist !== 12'h000) begin failures++; $display("FAIL avg_assist%0d: got ch=%b %h expected ch=1 000", k, a_ch, a_assist); end
        end
        checks++; if (consec !== 0) begin failures++; $display("FAIL no_consec_valid: got %0d expected 0", consec); end
    endtask
`endif

    initial begin
        dat[0][0] = 12'h000; dat[0][1] = 12'h000;
        dat[1][0] = 12'h000; dat[1][1] = 12'h000;
        test_reset();
`ifdef PHASE_ADC_AVG_EN
        test_avg();
        test_mosi();
`else
        test_basic();
        test_edges();
        test_mosi();
        test_mid_reset();
        test_fast();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
